// File: rtl/cnn_pkg.sv
// ============================================================================
// Module      : cnn_pkg
// Description : Shared types and limits for the elastic data pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

    localparam int MAX_STAGES = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

endpackage

`default_nettype wire

// File: rtl/data_skid_stage.sv
// ============================================================================
// Module      : data_skid_stage
// Description : One elastic stage (main + skid register) with a registered
//               ready. Optional flush under DATA_PIPE_REG_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_skid_stage
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
`ifdef DATA_PIPE_REG_FLUSH_EN
    input  logic                  i_flush,
`endif
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready
);

    stage_state_t          r_state;
    stage_state_t          w_state_nxt;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_main;
    logic [DATA_WIDTH-1:0] r_skid;
    logic                  w_in;
    logic                  w_out;
    logic                  w_load_main;
    logic                  w_load_skid;
    logic                  w_skid_to_main;

    assign w_in    = i_valid && r_ready;
    assign w_out   = (r_state != ST_EMPTY) && i_ready;
    assign o_ready = r_ready;
    assign o_valid = (r_state != ST_EMPTY);
    assign o_data  = r_main;

    always_comb begin
        w_state_nxt    = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in) begin
                    w_state_nxt = ST_BUSY;
                    w_load_main = 1'b1;
                end
            end
            ST_BUSY: begin
                if (w_in && w_out) begin
                    w_load_main = 1'b1;
                end else if (w_in) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (w_out) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out) begin
                    w_state_nxt    = ST_BUSY;
                    w_skid_to_main = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Ready is registered from the next state so it never depends on i_ready
    // combinationally, and stays low while reset is held.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_EMPTY;
            r_ready <= 1'b0;
            r_main  <= '0;
            r_skid  <= '0;
        end
`ifdef DATA_PIPE_REG_FLUSH_EN
        else if (i_flush) begin
            r_state <= ST_EMPTY;
            r_ready <= 1'b1;
        end
`endif
        else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != ST_FULL);
            if (w_load_main) begin
                r_main <= i_data;
            end else if (w_skid_to_main) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_pipe_reg.sv
// ============================================================================
// Module      : data_pipe_reg
// Description : Cascade of STAGES elastic skid stages (capacity 2*STAGES).
//               Define DATA_PIPE_REG_FLUSH_EN to add the i_flush port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_pipe_reg
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STAGES     = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
`ifdef DATA_PIPE_REG_FLUSH_EN
    input  logic                  i_flush,
`endif
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    input  logic                  i_data_ready
);

    // Out-of-range STAGES is clamped into the legal 1..MAX_STAGES window.
    localparam int c_NUM_STAGES = (STAGES > MAX_STAGES) ? MAX_STAGES :
                                  ((STAGES < 1) ? 1 : STAGES);

    logic [DATA_WIDTH-1:0] w_data  [0:c_NUM_STAGES];
    logic                  w_valid [0:c_NUM_STAGES];
    logic                  w_ready [0:c_NUM_STAGES];

    assign w_data[0]             = i_data;
    assign w_valid[0]            = i_data_valid;
    assign o_data_ready          = w_ready[0];
    assign o_data                = w_data[c_NUM_STAGES];
    assign o_data_valid          = w_valid[c_NUM_STAGES];
    assign w_ready[c_NUM_STAGES] = i_data_ready;

    genvar gi;
    generate
        for (gi = 0; gi < c_NUM_STAGES; gi++) begin : g_stage
            data_skid_stage #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_stage (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
`ifdef DATA_PIPE_REG_FLUSH_EN
                .i_flush (i_flush),
`endif
                .i_data  (w_data[gi]),
                .i_valid (w_valid[gi]),
                .o_ready (w_ready[gi]),
                .o_data  (w_data[gi+1]),
                .o_valid (w_valid[gi+1]),
                .i_ready (w_ready[gi+1])
            );
        end
    endgenerate

endmodule

`default_nettype wire
